// File: rtl/onchip_mem_test_pkg.sv
// Shared types and helpers for the on-chip RAM test master: FSM states,
// default geometry of the target RAM and the test pattern generator.
package onchip_mem_test_pkg;

  localparam int unsigned PKG_ADDR_W = 15;
  localparam int unsigned PKG_DATA_W = 32;
  localparam int unsigned PKG_DEPTH  = 25000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Word i of a test holds seed + i, wrapping modulo 2^DATA_W.
  function automatic logic [PKG_DATA_W-1:0] f_pattern(
    input logic [PKG_DATA_W-1:0] seed,
    input logic [PKG_ADDR_W-1:0] idx
  );
    return seed + PKG_DATA_W'(idx);
  endfunction

endpackage

// File: rtl/onchip_mem_test_checker.sv
// Read-back checker: holds the expected word/address of the read issued in the
// previous cycle, compares against readdata, and tracks mismatch statistics.
module onchip_mem_test_checker
  import onchip_mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W = PKG_ADDR_W,
  parameter int unsigned DATA_W = PKG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic              o_err_any_next
);

  logic              r_pv;
  logic [DATA_W-1:0] r_pexp;
  logic [ADDR_W-1:0] r_paddr;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first;
  logic              r_any;
  logic              w_mismatch;

  assign w_mismatch = r_pv && (i_rdata != r_pexp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv      <= 1'b0;
      r_pexp    <= '0;
      r_paddr   <= '0;
      r_err_cnt <= '0;
      r_first   <= '0;
      r_any     <= 1'b0;
    end else if (i_clear) begin
      r_pv      <= 1'b0;
      r_err_cnt <= '0;
      r_first   <= '0;
      r_any     <= 1'b0;
    end else begin
      r_pv    <= i_issue;
      r_pexp  <= i_exp;
      r_paddr <= i_addr;
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_any) r_first <= r_paddr;
        r_any <= 1'b1;
      end
    end
  end

  assign o_err_count      = r_err_cnt;
  assign o_first_err_addr = r_first;
  // Includes a mismatch being detected this cycle, so the verdict can be
  // registered on the same edge as the final comparison.
  assign o_err_any_next   = r_any | w_mismatch;

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM master that writes seed+i over a word range of the on-chip RAM,
// reads it back and reports mismatches. All bus outputs are registered.
module onchip_mem_test_master
  import onchip_mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W = PKG_ADDR_W,
  parameter int unsigned DATA_W = PKG_DATA_W,
  parameter int unsigned DEPTH  = PKG_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cfg_err,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata
);

  state_t              r_state, w_nxt_state;
  logic [ADDR_W-1:0]   r_idx, w_nxt_idx, w_idx_inc;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_last;
  logic [DATA_W-1:0]   r_seed;
  logic [ADDR_W-1:0]   r_addr, w_nxt_addr;
  logic                r_cs, w_nxt_cs;
  logic                r_we, w_nxt_we;
  logic [DATA_W-1:0]   r_wdata, w_nxt_wdata;
  logic [DATA_W/8-1:0] r_be;
  logic                r_busy, r_done, r_pass, r_cfg_err;
  logic [ADDR_W+1:0]   w_range_end;
  logic                w_bad_cfg, w_accept, w_last, w_rd_issue, w_err_any_next;
  logic [DATA_W-1:0]   w_pat_inc;

  assign w_range_end = (ADDR_W+2)'(base) + (ADDR_W+2)'(count);
  assign w_bad_cfg   = (count == '0) || (w_range_end > (ADDR_W+2)'(DEPTH));
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last      = ({1'b0, r_idx} == r_last);
  assign w_idx_inc   = r_idx + ADDR_W'(1);
  assign w_pat_inc   = DATA_W'(f_pattern(PKG_DATA_W'(r_seed), PKG_ADDR_W'(w_idx_inc)));
  assign w_rd_issue  = r_cs & ~r_we;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_addr  = r_addr;
    w_nxt_cs    = 1'b0;
    w_nxt_we    = 1'b0;
    w_nxt_wdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad_cfg) begin
            // Illegal range still passes through DRAIN so done lands on cycle 2.
            w_nxt_state = S_DRAIN;
          end else begin
            w_nxt_state = S_WRITE;
            w_nxt_idx   = '0;
            w_nxt_addr  = base;
            w_nxt_cs    = 1'b1;
            w_nxt_we    = 1'b1;
            w_nxt_wdata = DATA_W'(f_pattern(PKG_DATA_W'(seed), '0));
          end
        end
      end
      S_WRITE: begin
        w_nxt_cs = 1'b1;
        if (w_last) begin
          w_nxt_state = S_READ;
          w_nxt_idx   = '0;
          w_nxt_addr  = r_base;
          w_nxt_we    = 1'b0;
          w_nxt_wdata = r_seed;
        end else begin
          w_nxt_idx   = w_idx_inc;
          w_nxt_addr  = r_base + w_idx_inc;
          w_nxt_we    = 1'b1;
          w_nxt_wdata = w_pat_inc;
        end
      end
      S_READ: begin
        // writedata keeps tracking the pattern; it is the expected read value.
        if (w_last) begin
          w_nxt_state = S_DRAIN;
        end else begin
          w_nxt_cs    = 1'b1;
          w_nxt_idx   = w_idx_inc;
          w_nxt_addr  = r_base + w_idx_inc;
          w_nxt_wdata = w_pat_inc;
        end
      end
      S_DRAIN: w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_base    <= '0;
      r_last    <= '0;
      r_seed    <= '0;
      r_addr    <= '0;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_addr  <= w_nxt_addr;
      r_cs    <= w_nxt_cs;
      r_we    <= w_nxt_we;
      r_wdata <= w_nxt_wdata;
      r_be    <= w_nxt_cs ? '1 : '0;
      r_busy  <= (w_nxt_state != S_IDLE);
      r_done  <= (w_nxt_state == S_DONE);
      if (w_accept) begin
        r_cfg_err <= w_bad_cfg;
        r_pass    <= 1'b0;
        if (!w_bad_cfg) begin
          r_base <= base;
          r_seed <= seed;
          r_last <= count - (ADDR_W+1)'(1);
        end
      end
      if (r_state == S_DRAIN) r_pass <= !r_cfg_err && !w_err_any_next;
    end
  end

  onchip_mem_test_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk              (clk),
    .reset            (reset),
    .i_clear          (w_accept),
    .i_issue          (w_rd_issue),
    .i_addr           (r_addr),
    .i_exp            (r_wdata),
    .i_rdata          (readdata),
    .o_err_count      (err_count),
    .o_first_err_addr (first_err_addr),
    .o_err_any_next   (w_err_any_next)
  );

  assign address    = r_addr;
  assign byteenable = r_be;
  assign chipselect = r_cs;
  assign write      = r_we;
  assign writedata  = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_onchip_mem_test_master.sv
// Scoreboard bench for onchip_mem_test_master: a behavioural RAM with fault
// injection, a reference model of expected bus traffic/results, and a monitor.
module tb_onchip_mem_test_master;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 25000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass, cfg_err;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, address;
  logic [DW/8-1:0] byteenable;
  logic          chipselect, write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata = '0;

  always #5 clk = ~clk;

  onchip_mem_test_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base           (base),
    .count          (count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .cfg_err        (cfg_err),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .address        (address),
    .byteenable     (byteenable),
    .chipselect     (chipselect),
    .write          (write),
    .writedata      (writedata),
    .readdata       (readdata)
  );

  // Behavioural RAM: mode 0 clean, mode 1 flips bit 0 of one word on read,
  // mode 2 reads back all zeros.
  logic [DW-1:0] mem [DEPTH];
  int unsigned   fault_mode = 0;
  logic [AW-1:0] fault_addr = '0;

  always @(posedge clk) begin
    if (chipselect && (int'(address) < DEPTH)) begin
      if (write) mem[address] <= writedata;
      else readdata <= (fault_mode == 2) ? '0 :
                       (mem[address] ^ ((fault_mode == 1 && address == fault_addr) ? 32'd1 : 32'd0));
    end
  end

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int unsigned   off;
    bit            pass;
    bit            cfg;
    int unsigned   errc;
    logic [AW-1:0] fea;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  res_t        last_res;
  acc_t        mon_a;
  res_t        mon_r;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM access and every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (chipselect) begin
        n_checks++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_access: got addr 0x%0h write %0b, expected no access", address, write);
        end else begin
          mon_a = acc_q.pop_front();
          check("acc_addr", 64'(address), 64'(mon_a.addr));
          check("acc_write", 64'(write), 64'(mon_a.we));
          check("acc_byteenable", 64'(byteenable), 64'hF);
          if (mon_a.we) check("acc_writedata", 64'(writedata), 64'(mon_a.data));
        end
      end
      if (done) begin
        n_checks++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          mon_r = res_q.pop_front();
          check("done_cycle", 64'(cyc - start_cyc), 64'(mon_r.off));
          check("busy_at_done", 64'(busy), 64'd1);
          check("pass", 64'(pass), 64'(mon_r.pass));
          check("cfg_err", 64'(cfg_err), 64'(mon_r.cfg));
          check("err_count", 64'(err_count), 64'(mon_r.errc));
          check("first_err_addr", 64'(first_err_addr), 64'(mon_r.fea));
        end
      end
    end
  end

  // Reference model: builds the expected traffic and verdict from the rules.
  task automatic issue_test(input logic [AW-1:0] b, input logic [AW:0] c, input logic [DW-1:0] s,
                            input int unsigned mode, input int unsigned cw);
    res_t        r;
    acc_t        a;
    int unsigned errs;
    bit          found;
    logic [DW-1:0] w;
    r.fea = '0;
    if (c == 0 || int'(b) + int'(c) > int'(DEPTH)) begin
      r.off = 2; r.pass = 1'b0; r.cfg = 1'b1; r.errc = 0;
    end else begin
      for (int unsigned i = 0; i < int'(c); i++) begin
        a.we = 1'b1; a.addr = AW'(int'(b) + i); a.data = s + DW'(i);
        acc_q.push_back(a);
      end
      for (int unsigned i = 0; i < int'(c); i++) begin
        a.we = 1'b0; a.addr = AW'(int'(b) + i); a.data = '0;
        acc_q.push_back(a);
      end
      errs = 0; found = 1'b0;
      for (int unsigned i = 0; i < int'(c); i++) begin
        w = s + DW'(i);
        if ((mode == 2 && w != 0) || (mode == 1 && i == cw)) begin
          errs++;
          if (!found) r.fea = AW'(int'(b) + i);
          found = 1'b1;
        end
      end
      r.off  = 2 * int'(c) + 2;
      r.pass = (errs == 0);
      r.cfg  = 1'b0;
      r.errc = (errs > 65535) ? 65535 : errs;
    end
    res_q.push_back(r);
    last_res   = r;
    fault_mode = mode;
    fault_addr = AW'(int'(b) + cw);
    @(posedge clk); #1;
    base = b; count = c; seed = s; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_test(input int unsigned limit);
    int unsigned n = 0;
    while (res_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("test_completed", 64'(res_q.size()), 64'd0);
    check("accesses_consumed", 64'(acc_q.size()), 64'd0);
    res_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("hold_pass", 64'(pass), 64'(last_res.pass));
    check("hold_cfg_err", 64'(cfg_err), 64'(last_res.cfg));
    check("hold_err_count", 64'(err_count), 64'(last_res.errc));
    check("hold_first_err_addr", 64'(first_err_addr), 64'(last_res.fea));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_byteenable"}, 64'(byteenable), 64'd0);
    check({tag, "_chipselect"}, 64'(chipselect), 64'd0);
    check({tag, "_write"}, 64'(write), 64'd0);
    check({tag, "_writedata"}, 64'(writedata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    logic [AW:0]   rc;
    #1 reset = 1'b1;
    #2 check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue_test(AW'(0), 16'd16, 32'h1000_0000, 0, 0);    wait_test(50);
    issue_test(AW'(0), 16'd16, 32'h1000_0000, 1, 5);    wait_test(50);
    issue_test(AW'(24990), 16'd11, 32'h0000_1234, 0, 0); wait_test(10);
    issue_test(AW'(7), 16'd0, 32'h0000_0055, 0, 0);      wait_test(10);
    issue_test(AW'(24999), 16'd1, 32'hA5A5_0000, 0, 0);  wait_test(14);
    issue_test(AW'(100), 16'd4, 32'hFFFF_FFFE, 0, 0);    wait_test(20);

    for (int t = 0; t < 8; t++) begin
      rc = (AW+1)'($urandom_range(1, 40));
      rb = AW'($urandom_range(0, DEPTH - int'(rc)));
      issue_test(rb, rc, $urandom, $urandom_range(0, 2), $urandom_range(0, int'(rc) + 2));
      wait_test(2 * int'(rc) + 10);
    end
    rb = AW'($urandom_range(DEPTH - 40, 32767));
    rc = (AW+1)'($urandom_range(41, 100));
    issue_test(rb, rc, $urandom, 0, 0);
    wait_test(10);

    // Reset during READ, then a second start while busy must be ignored.
    issue_test(AW'(40), 16'd8, $urandom, 0, 0);
    repeat (11) @(posedge clk);
    #2 reset = 1'b1;
    acc_q.delete();
    res_q.delete();
    #1 check_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue_test(AW'(200), 16'd10, $urandom, 0, 0);
    repeat (3) @(posedge clk);
    #1 base = '0; count = '0; seed = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_test(30);

    issue_test(AW'(0), 16'd25000, 32'h0000_0001, 2, 0);
    wait_test(50010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
